// File: rtl/hcsr04_scan.sv
// hcsr04_scan: round-robin controller for several HC-SR04-class ultrasonic
// sensors. Fires one channel at a time, times the echo in microseconds,
// converts it to millimetres and reports timeouts. A quiet holdoff follows
// every result so late reflections cannot reach the next channel.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start with at least one channel enabled
// S_TRIG    | trigger pin of the current channel high for TRIG_US
// S_WAIT    | waiting for a fresh rising edge on the current echo
// S_MEAS    | counting microseconds while the echo stays high
// S_CALC    | converting the count to millimetres, issuing the result
// S_HOLD    | quiet gap, then pick the next channel or stop
module hcsr04_scan #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int N_CH       = 4,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 38000,
  parameter int HOLDOFF_US = 60000,
  parameter int DIST_W     = 13,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic [N_CH-1:0]   i_ch_en,
  input  logic [N_CH-1:0]   i_echo,
  output logic [N_CH-1:0]   o_trig,
  output logic              o_busy,
  output logic              o_val,
  output logic [CH_W-1:0]   o_ch,
  output logic [DIST_W-1:0] o_distance,
  output logic              o_tout
);

  localparam int DIV    = CLK_HZ / 1_000_000;
  localparam int PRE_W  = $clog2(DIV);
  localparam int US_MAX = (TIMEOUT_US > HOLDOFF_US)
                          ? ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US)
                          : ((HOLDOFF_US > TRIG_US) ? HOLDOFF_US : TRIG_US);
  localparam int US_W   = $clog2(US_MAX + 1);
  localparam int PROD_W = (US_W + 14 > 32) ? (US_W + 14) : 32;
  // 11242 / 65536 ~= 0.1715 mm per us (speed of sound, round trip halved)
  localparam logic [PROD_W-1:0] K_MM     = PROD_W'(11242);
  localparam logic [PROD_W-1:0] DIST_MAX = PROD_W'((64'd1 << DIST_W) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_CALC, S_HOLD
  } state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_cur;
  logic [PRE_W-1:0]  r_pre;
  logic [US_W-1:0]   r_us;
  logic [N_CH-1:0]   r_trig;
  logic [N_CH-1:0]   r_sync1, r_sync2, r_sync3;

  logic              w_tick;
  logic              w_echo, w_rise, w_fall;
  logic              w_low_ok, w_nxt_ok, w_go;
  logic [CH_W-1:0]   w_low, w_nxt, w_go_ch;
  logic [PROD_W-1:0] w_prod, w_quo;
  logic [DIST_W-1:0] w_dist;

  // Two-flop synchroniser plus one history stage for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= i_echo;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_echo = r_sync2[r_cur];
  assign w_rise = r_sync2[r_cur] & ~r_sync3[r_cur];
  assign w_fall = ~r_sync2[r_cur] & r_sync3[r_cur];
  assign w_tick = (r_pre == PRE_W'(DIV - 1));

  // Lowest enabled channel and lowest enabled channel above the current one
  always_comb begin
    w_low_ok = 1'b0;
    w_low    = '0;
    w_nxt_ok = 1'b0;
    w_nxt    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_ch_en[i]) begin
        w_low_ok = 1'b1;
        w_low    = CH_W'(i);
        if (CH_W'(i) > r_cur) begin
          w_nxt_ok = 1'b1;
          w_nxt    = CH_W'(i);
        end
      end
    end
  end

  assign w_go    = w_nxt_ok | (i_cont & w_low_ok);
  assign w_go_ch = w_nxt_ok ? w_nxt : w_low;

  assign w_prod = PROD_W'(r_us) * K_MM;
  assign w_quo  = w_prod >> 16;
  assign w_dist = (w_quo > DIST_MAX) ? DIST_W'(DIST_MAX) : w_quo[DIST_W-1:0];

  // Sequencer: prescaler, us counter, trigger pins and result registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_pre      <= '0;
      r_us       <= '0;
      r_trig     <= '0;
      o_val      <= 1'b0;
      o_ch       <= '0;
      o_distance <= '0;
      o_tout     <= 1'b0;
    end else begin
      o_val <= 1'b0;
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_start && w_low_ok) begin
            r_cur   <= w_low;
            r_trig  <= N_CH'(1) << w_low;
            r_pre   <= '0;
            r_us    <= '0;
            r_state <= S_TRIG;
          end
        end
        S_TRIG: begin
          if (w_tick) begin
            if (r_us == US_W'(TRIG_US - 1)) begin
              r_trig  <= '0;
              r_pre   <= '0;
              r_us    <= '0;
              r_state <= S_WAIT;
            end else begin
              r_us <= r_us + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (w_rise) begin
            r_pre   <= '0;
            r_us    <= '0;
            r_state <= S_MEAS;
          end else if (w_tick) begin
            if (r_us == US_W'(TIMEOUT_US - 1)) begin
              o_val      <= 1'b1;
              o_ch       <= r_cur;
              o_distance <= '0;
              o_tout     <= 1'b1;
              r_pre      <= '0;
              r_us       <= '0;
              r_state    <= S_HOLD;
            end else begin
              r_us <= r_us + 1'b1;
            end
          end
        end
        S_MEAS: begin
          if (w_fall) begin
            r_state <= S_CALC;
          end else if (w_tick && w_echo) begin
            // the echo is abandoned the moment the count would hit the limit
            if (r_us == US_W'(TIMEOUT_US - 1)) begin
              o_val      <= 1'b1;
              o_ch       <= r_cur;
              o_distance <= '0;
              o_tout     <= 1'b1;
              r_pre      <= '0;
              r_us       <= '0;
              r_state    <= S_HOLD;
            end else begin
              r_us <= r_us + 1'b1;
            end
          end
        end
        S_CALC: begin
          o_val      <= 1'b1;
          o_ch       <= r_cur;
          o_distance <= w_dist;
          o_tout     <= 1'b0;
          r_pre      <= '0;
          r_us       <= '0;
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          if (w_tick) begin
            if (r_us == US_W'(HOLDOFF_US - 1)) begin
              r_us <= '0;
              if (w_go) begin
                r_cur   <= w_go_ch;
                r_trig  <= N_CH'(1) << w_go_ch;
                r_pre   <= '0;
                r_state <= S_TRIG;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_us <= r_us + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_trig = r_trig;
  assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_hcsr04_scan.sv
// Directed bench for hcsr04_scan. Three instances share one 4 MHz clock
// (4 cycles per us) so long echoes stay cheap to simulate:
//   A: TIMEOUT 6000 us, holdoff 100 us, 13-bit distance (sweep, reset)
//   B: TIMEOUT 200 us,  holdoff 100 us (timeouts, stuck and long echoes)
//   C: TIMEOUT 3000 us, holdoff 20 us, 8-bit distance (saturation, cont)
// Echo widths are N us plus 2 cycles to absorb the synchroniser skew.
`timescale 1ns/1ps
module tb_hcsr04_scan;

  localparam int CLK_HZ = 4_000_000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        a_start = 0, a_cont = 0;
  logic [3:0]  a_ch_en = '0, a_echo = '0, a_trig;
  logic        a_busy, a_val, a_tout;
  logic [1:0]  a_ch;
  logic [12:0] a_dist;

  logic        b_start = 0, b_cont = 0;
  logic [3:0]  b_ch_en = '0, b_echo = '0, b_trig;
  logic        b_busy, b_val, b_tout;
  logic [1:0]  b_ch;
  logic [12:0] b_dist;

  logic        c_start = 0, c_cont = 0;
  logic [3:0]  c_ch_en = '0, c_echo = '0, c_trig;
  logic        c_busy, c_val, c_tout;
  logic [1:0]  c_ch;
  logic [7:0]  c_dist;

  hcsr04_scan #(.CLK_HZ(CLK_HZ), .N_CH(4), .TRIG_US(10), .TIMEOUT_US(6000),
                .HOLDOFF_US(100), .DIST_W(13)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_cont(a_cont),
    .i_ch_en(a_ch_en), .i_echo(a_echo), .o_trig(a_trig), .o_busy(a_busy),
    .o_val(a_val), .o_ch(a_ch), .o_distance(a_dist), .o_tout(a_tout));

  hcsr04_scan #(.CLK_HZ(CLK_HZ), .N_CH(4), .TRIG_US(10), .TIMEOUT_US(200),
                .HOLDOFF_US(100), .DIST_W(13)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_cont(b_cont),
    .i_ch_en(b_ch_en), .i_echo(b_echo), .o_trig(b_trig), .o_busy(b_busy),
    .o_val(b_val), .o_ch(b_ch), .o_distance(b_dist), .o_tout(b_tout));

  hcsr04_scan #(.CLK_HZ(CLK_HZ), .N_CH(4), .TRIG_US(10), .TIMEOUT_US(3000),
                .HOLDOFF_US(20), .DIST_W(8)) u_c (
    .i_clk(clk), .i_rst(rst), .i_start(c_start), .i_cont(c_cont),
    .i_ch_en(c_ch_en), .i_echo(c_echo), .o_trig(c_trig), .o_busy(c_busy),
    .o_val(c_val), .o_ch(c_ch), .o_distance(c_dist), .o_tout(c_tout));

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({a_trig, b_trig, c_trig} !== 12'h000) begin failures++; $display("FAIL reset_trig actual=%h required=000", {a_trig, b_trig, c_trig}); end
    checks++; if ({a_busy, a_val, a_tout} !== 3'b000) begin failures++; $display("FAIL reset_flags actual=%b required=000", {a_busy, a_val, a_tout}); end
    checks++; if (a_ch !== 2'd0 || a_dist !== 13'd0) begin failures++; $display("FAIL reset_result actual=%0d/%0d required=0/0", a_ch, a_dist); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset actual=%b required=0", a_busy); end
  endtask

  // one channel of an A sweep: trig shape, echo, then result latency/values
  task automatic a_channel(input int ch, input int echo_cyc, input int exp_dist);
    int n;
    logic [3:0] oh;
    logic bad, early;
    oh = 4'b0001 << ch;
    n = 0;
    while (a_trig == 4'b0 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (a_trig !== oh) begin failures++; $display("FAIL trig_select ch%0d actual=%b required=%b", ch, a_trig, oh); end
    n = 0; bad = 1'b0;
    while (a_trig != 4'b0 && n < 100) begin
      if (a_trig !== oh) bad = 1'b1;
      @(negedge clk); n++;
    end
    checks++; if (n !== 40 || bad) begin failures++; $display("FAIL trig_width ch%0d actual=%0d stray=%b required=40 stray=0", ch, n, bad); end
    repeat (10) @(negedge clk);
    a_echo[ch] = 1'b1;
    repeat (echo_cyc) @(negedge clk);
    a_echo[ch] = 1'b0;
    early = 1'b0;
    repeat (3) begin @(negedge clk); if (a_val) early = 1'b1; end
    @(negedge clk);
    checks++; if (a_val !== 1'b1 || early) begin failures++; $display("FAIL val_latency ch%0d actual=%b early=%b required=1 early=0", ch, a_val, early); end
    checks++; if (a_ch !== 2'(ch)) begin failures++; $display("FAIL result_ch actual=%0d required=%0d", a_ch, ch); end
    checks++; if (a_dist !== 13'(exp_dist)) begin failures++; $display("FAIL result_dist ch%0d actual=%0d required=%0d", ch, a_dist, exp_dist); end
    checks++; if (a_tout !== 1'b0) begin failures++; $display("FAIL result_tout ch%0d actual=%b required=0", ch, a_tout); end
    @(negedge clk);
    checks++; if (a_val !== 1'b0) begin failures++; $display("FAIL val_one_cycle ch%0d actual=%b required=0", ch, a_val); end
  endtask

  task automatic test_sweep();
    int n;
    @(negedge clk);
    a_ch_en = 4'b0101; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    checks++; if (a_trig !== 4'b0001) begin failures++; $display("FAIL trig_after_start actual=%b required=0001", a_trig); end
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL busy_sweep actual=%b required=1", a_busy); end
    a_channel(0, 5830 * 4 + 2, 1000);
    n = 1;
    while (a_trig == 4'b0 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n !== 400) begin failures++; $display("FAIL holdoff_gap actual=%0d required=400", n); end
    a_channel(2, 1000 * 4 + 2, 171);
    n = 1;
    while (a_busy && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n !== 400 || a_busy !== 1'b0) begin failures++; $display("FAIL busy_fall actual=%0d busy=%b required=400 busy=0", n, a_busy); end
  endtask

  task automatic test_timeout();
    int n;
    @(negedge clk);
    b_ch_en = 4'b0110; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    checks++; if (b_trig !== 4'b0010) begin failures++; $display("FAIL b_trig_ch1 actual=%b required=0010", b_trig); end
    n = 0;
    while (b_trig != 4'b0 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!b_val && n < 2000) begin @(negedge clk); n++; end
    checks++; if (n < 797 || n > 803) begin failures++; $display("FAIL timeout_delay actual=%0d required=800+-3", n); end
    checks++; if (b_ch !== 2'd1 || b_tout !== 1'b1 || b_dist !== 13'd0) begin failures++; $display("FAIL timeout_result actual=ch%0d tout%b d%0d required=ch1 tout1 d0", b_ch, b_tout, b_dist); end
    // echo on ch 2 stuck high from before its trigger and never released
    b_echo[2] = 1'b1;
    n = 0;
    while (b_trig == 4'b0 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (b_trig !== 4'b0100) begin failures++; $display("FAIL sweep_continues actual=%b required=0100", b_trig); end
    n = 0;
    while (b_trig != 4'b0 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!b_val && n < 2000) begin @(negedge clk); n++; end
    checks++; if (n < 797 || n > 803) begin failures++; $display("FAIL stuck_delay actual=%0d required=800+-3", n); end
    checks++; if (b_ch !== 2'd2 || b_tout !== 1'b1) begin failures++; $display("FAIL stuck_result actual=ch%0d tout%b required=ch2 tout1", b_ch, b_tout); end
    n = 0;
    while (b_busy && n < 1000) begin @(negedge clk); n++; end
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL b_sweep_end actual=%b required=0", b_busy); end
    b_echo[2] = 1'b0;
  endtask

  task automatic test_long_echo();
    int n, vals;
    @(negedge clk);
    b_ch_en = 4'b0001; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    n = 0;
    while (b_trig != 4'b0 && n < 100) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    b_echo[0] = 1'b1;
    n = 0;
    while (!b_val && n < 1600) begin @(negedge clk); n++; end
    checks++; if (n < 800 || n > 806) begin failures++; $display("FAIL long_echo_delay actual=%0d required=803+-3", n); end
    checks++; if (b_tout !== 1'b1 || b_dist !== 13'd0 || b_ch !== 2'd0) begin failures++; $display("FAIL long_echo_result actual=tout%b d%0d ch%0d required=tout1 d0 ch0", b_tout, b_dist, b_ch); end
    repeat (100) @(negedge clk);
    b_echo[0] = 1'b0;
    n = 0; vals = 0;
    while (b_busy && n < 1000) begin @(negedge clk); n++; if (b_val) vals++; end
    checks++; if (vals !== 0 || b_busy !== 1'b0) begin failures++; $display("FAIL long_echo_tail actual=vals%0d busy%b required=vals0 busy0", vals, b_busy); end
  endtask

  // single C sweep on channel 0 with a given echo width, returns at the val
  task automatic c_shot(input int echo_cyc);
    int n;
    n = 0;
    while (c_trig == 4'b0 && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (c_trig != 4'b0 && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    c_echo[0] = 1'b1;
    repeat (echo_cyc) @(negedge clk);
    c_echo[0] = 1'b0;
    n = 0;
    while (!c_val && n < 10) begin @(negedge clk); n++; end
  endtask

  task automatic test_saturation();
    int n;
    @(negedge clk);
    c_ch_en = 4'b0001; c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    c_shot(2000 * 4 + 2);
    checks++; if (c_val !== 1'b1 || c_dist !== 8'd255 || c_tout !== 1'b0) begin failures++; $display("FAIL saturate actual=val%b d%0d tout%b required=val1 d255 tout0", c_val, c_dist, c_tout); end
    n = 0;
    while (c_busy && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    c_shot(600 * 4 + 2);
    checks++; if (c_val !== 1'b1 || c_dist !== 8'd102 || c_tout !== 1'b0) begin failures++; $display("FAIL unsaturated actual=val%b d%0d tout%b required=val1 d102 tout0", c_val, c_dist, c_tout); end
    n = 0;
    while (c_busy && n < 500) begin @(negedge clk); n++; end
  endtask

  task automatic test_cont();
    int n, act;
    @(negedge clk);
    c_ch_en = 4'b0001; c_cont = 1'b1; c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (c_trig == 4'b0 && n < 1000) begin @(negedge clk); n++; end
      checks++; if (c_trig !== 4'b0001) begin failures++; $display("FAIL cont_retrigger round%0d actual=%b required=0001", r, c_trig); end
      if (r == 0) begin
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
      end
      c_shot(100 * 4 + 2);
      checks++; if (c_val !== 1'b1 || c_ch !== 2'd0 || c_dist !== 8'd17 || c_tout !== 1'b0) begin failures++; $display("FAIL cont_result round%0d actual=val%b ch%0d d%0d tout%b required=val1 ch0 d17 tout0", r, c_val, c_ch, c_dist, c_tout); end
      if (r == 1) begin
        @(negedge clk);
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
      end
    end
    c_cont = 1'b0;
    n = 0;
    while (c_busy && n < 500) begin @(negedge clk); n++; end
    checks++; if (c_busy !== 1'b0) begin failures++; $display("FAIL cont_stop actual=%b required=0", c_busy); end
    act = 0;
    repeat (300) begin @(negedge clk); if (c_busy || c_trig != 4'b0) act++; end
    checks++; if (act !== 0) begin failures++; $display("FAIL no_queued_start actual=%0d active cycles required=0", act); end
  endtask

  task automatic test_reset_mid();
    int n, vals;
    @(negedge clk);
    a_ch_en = 4'b0101; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (a_trig !== 4'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL reset_drops_trig actual=trig%b busy%b required=trig0000 busy0", a_trig, a_busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    n = 0;
    while (a_trig != 4'b0 && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    a_echo[0] = 1'b1;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({a_trig, a_busy, a_val, a_tout} !== 7'b0) begin failures++; $display("FAIL reset_mid_flags actual=%b required=0000000", {a_trig, a_busy, a_val, a_tout}); end
    checks++; if (a_ch !== 2'd0 || a_dist !== 13'd0) begin failures++; $display("FAIL reset_mid_result actual=ch%0d d%0d required=ch0 d0", a_ch, a_dist); end
    repeat (2) @(negedge clk);
    a_echo[0] = 1'b0;
    rst = 1'b0;
    vals = 0;
    repeat (100) begin @(negedge clk); if (a_val || a_busy) vals++; end
    checks++; if (vals !== 0) begin failures++; $display("FAIL no_val_after_reset actual=%0d required=0", vals); end
    a_ch_en = 4'b0110; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    checks++; if (a_trig !== 4'b0010) begin failures++; $display("FAIL fresh_sweep actual=%b required=0010", a_trig); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_timeout();
    test_long_echo();
    test_saturation();
    test_cont();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hcsr04_scan.md
# hcsr04_scan

Multi-channel ultrasonic ranging controller for up to N_CH HC-SR04-class sensors sharing one controller. It fires channels one at a time in round-robin order, which avoids acoustic crosstalk between sensors. For each echo it measures the pulse width in microseconds and converts it to millimetres with a fixed-point multiply. Sits between the sensor pins and the distance consumer; it is the parametrised successor of the single-sensor driver and adds channel masking, continuous scan, timeout reporting and holdoff.

## Interface
- CLK_HZ, 100_000_000, clock frequency; DIV = CLK_HZ/1_000_000 cycles per µs tick (integer, ≥ 2)
- N_CH, 4, number of sensor channels (1..16)
- TRIG_US, 10, trigger pulse width in µs
- TIMEOUT_US, 38000, maximum echo wait and maximum echo width, in µs
- HOLDOFF_US, 60000, quiet gap after every channel result, in µs
- DIST_W, 13, distance output width in bits
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE
- cont  in  1  continuous mode: re-sweep automatically after the last channel
- ch_en  in  N_CH  channel enable mask; disabled channels are skipped
- echo  in  N_CH  raw echo pins, asynchronous
- trig  out  N_CH  trigger pins; at most one bit is high at any time
- busy  out  1  high whenever state ≠ IDLE
- val  out  1  one-cycle result strobe
- ch  out  max(1,$clog2(N_CH))  channel of the current result; held until the next val
- distance  out  DIST_W  distance in mm; held until the next val
- tout  out  1  result is a timeout; held until the next val

## Operation
- Reset values: trig=0, busy=0, val=0, ch=0, distance=0, tout=0, state IDLE, all counters 0.
- Each echo bit passes through a 2-FF synchroniser and then a rising/falling edge detector.
- A µs prescaler counts 0..DIV-1. It restarts at 0 on entry to TRIG, WAIT_ECHO and MEASURE, and on every HOLDOFF entry. Each wrap produces one µs tick.
- States:
  - IDLE: on start with ch_en≠0, select the lowest enabled channel and go to TRIG. start with ch_en=0 is ignored.
  - TRIG: trig[ch] high for exactly TRIG_US·DIV cycles, then low, then go to WAIT_ECHO.
  - WAIT_ECHO: wait for a synchronised rising edge on echo[ch]. An echo already high on entry does not count. Rising edge: clear us_cnt and go to MEASURE. TIMEOUT_US ticks with no edge: result with tout=1, distance=0.
  - MEASURE: us_cnt increments on each tick while echo is high. Falling edge: go to CALC. us_cnt reaching TIMEOUT_US: result with tout=1, distance=0, without waiting for the falling edge.
  - CALC: distance = (us_cnt·11242)>>16, saturated to 2^DIST_W−1, with tout=0. The product is at least 32 bits wide.
  - Result: val pulses for one cycle; ch, distance and tout update in that same cycle; then go to HOLDOFF.
  - HOLDOFF: wait HOLDOFF_US ticks, then select the next enabled channel above ch and go to TRIG. If there is none:
    - cont=1 and ch_en≠0: wrap to the lowest enabled channel and go to TRIG.
    - Otherwise: go to IDLE.
- Channel selection and cont are both sampled at HOLDOFF exit. ch_en changes made mid-sweep therefore take effect on the next selection.
- start while busy is ignored; no queuing.
- Reset mid-operation drops trig immediately (async) and discards any in-flight measurement; no val is issued.

## Timing
- Pin-to-strobe latency: val asserts exactly 4 clk edges after the first edge that samples the echo pin low (2 sync + 1 detect + 1 CALC).
- trig[ch] rises on the cycle after start is sampled in IDLE and is high for exactly TRIG_US·DIV cycles.
- Measurement resolution is 1 µs: us_cnt = floor(echo-high cycles / DIV) with a ±1-cycle sync skew.
- Channel-to-channel period is the echo/timeout time + HOLDOFF_US + TRIG_US + a few cycles.

## Test plan
- Single sweep, N_CH=4, ch_en=4'b0101, CLK_HZ=100 MHz, HOLDOFF_US=100 -> stimulus: echo0 high 5830 µs, echo2 high 1000 µs -> required: val twice; first (ch=0, distance=1000, tout=0), then (ch=2, distance=171, tout=0); channels 1 and 3 never see trig; busy falls after the ch 2 holdoff; trig width exactly 1000 cycles each.
- No echo on ch 1, TIMEOUT_US=200 -> required: val with ch=1, tout=1, distance=0 exactly 200 µs after trig fall (±3 cycles); the sweep continues.
- Stuck echo: echo high before trig and never falling -> required: no measurement starts on the pre-existing level; result is tout=1.
- Echo longer than TIMEOUT_US=200 -> required: tout=1 at us_cnt=200, before echo falls; with DIST_W=8 and an echo of 2000 µs (TIMEOUT raised), distance saturates to 255.
- cont=1, ch_en=4'b0001 -> required: ch 0 is re-triggered after each holdoff; deasserting cont stops after the current holdoff with busy=0; start pulses during busy have no effect.
- rst asserted mid-MEASURE with trig/val activity -> required: all outputs at reset values immediately; no val; a start after release begins a fresh sweep from the lowest enabled channel.
